ws2812_rx: RTL and testbench
============================

Name: ws2812_rx

Overview:
- Single-wire WS2812B line decoder: the receive end of the protocol our LED transmitter drives onto the PMOD pin.
- Samples the serial line, classifies each high pulse as a 0 or 1 bit, and assembles 24-bit GRB pixels, MSB first.
- Detects the latch (reset) gap that ends a frame.
- Used for on-board loopback self-check of the transmitter (jumper between PMOD pins) and as a building block for chained-strip emulation.

Parameters:
- T_MIN_HIGH, 15: high pulses shorter than this many clk cycles are glitches and are ignored.
- T_THRESH, 60: high time >= T_THRESH cycles decodes as 1; below it decodes as 0.
- T_MAX_HIGH, 110: high time >= this is a protocol error; the counter saturates here.
- T_LATCH, 5000: consecutive low cycles (50 us at 100 MHz) that constitute a latch/reset.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-high reset
- lineIn  input  1  raw WS2812B data line (asynchronous to clk)
- pixel  output  24  last completed pixel, {G,R,B}, first-received bit in [23]
- pixelValid  output  1  one-cycle pulse when pixel updates
- pixelCount  output  8  pixels completed in the current frame, saturates at 255
- frameDone  output  1  one-cycle pulse on latch detection after at least one bit
- frameLen  output  8  pixelCount captured at frameDone
- bitErr  output  1  one-cycle pulse on an over-long high pulse or a partial pixel at latch

Behaviour:
- Reset (async, active-high): all outputs 0, synchronizer flops 0, state WAIT_LATCH, all counters 0, shift register 0.
- Input handling:
  - lineIn passes through a 2-flop synchronizer, giving s; sPrev is s delayed one cycle.
  - Rise = s & ~sPrev. Fall = ~s & sPrev.
- State WAIT_LATCH (frame sync after reset or error):
  - Count consecutive low cycles of s; any high clears the count.
  - At T_LATCH go to IDLE. No outputs pulse here.
- State IDLE: a rise goes to HIGH and sets highCnt to 1.
- State HIGH:
  - highCnt increments each cycle s is high, saturating at T_MAX_HIGH (8-bit counter).
  - On fall, classify highCnt:
    - highCnt < T_MIN_HIGH: glitch. Discard, no bit, go to LOW.
    - highCnt >= T_MAX_HIGH: pulse bitErr, clear bitCnt and the shift register, go to WAIT_LATCH.
    - Otherwise: bit = (highCnt >= T_THRESH). Shift it in MSB first and increment bitCnt (0..23). Go to LOW.
- Pixel completion:
  - When the bit that makes bitCnt reach 24 is accepted, load pixel with {shift[22:0], bit} in the cycle after the fall is seen.
  - Same cycle: pixelValid = 1, bitCnt returns to 0, pixelCount increments (saturating at 255).
  - Latency: 3 clk from lineIn falling to pixelValid high.
- State LOW:
  - lowCnt (13-bit, saturating at T_LATCH) counts low cycles. A rise goes to HIGH with highCnt = 1 and lowCnt cleared.
  - Low gaps of any length below T_LATCH are accepted; no minimum-period check.
  - When lowCnt reaches T_LATCH:
    - Pulse frameDone.
    - frameLen takes pixelCount (the value including any pixel completed the same cycle).
    - If bitCnt != 0, also pulse bitErr.
    - Clear pixelCount, bitCnt and shift, then go to IDLE.
- frameDone is not generated for a latch that saw no bits since the previous latch: IDLE stays IDLE.
- pixel holds its value until the next pixel completes; it is not cleared at frameDone.
- Line stuck high: highCnt saturates and no outputs change until the fall, which then produces bitErr.
- Reset mid-frame: immediate return to reset values; the partial pixel is lost. The next frame is accepted only after a full T_LATCH low period.

Decomposition:
- Shared package ws2812_pkg holds:
  - the timing constants (T0H/T1H/period/latch cycle counts at 100 MHz), which the transmitter side also uses;
  - the state encoding (WAIT_LATCH, IDLE, HIGH, LOW).
- One sub-module, ws2812_pulse_meas, contains the synchronizer, edge detect, highCnt and lowCnt. It outputs bitStrobe, bitVal, glitch, tooLong and latchSeen.
- The FSM, shift register and pixel counters stay in ws2812_rx.

Test Plan:
- Startup sync: after reset, low for 5000 cycles, then 24 bits of 0xFF0000 (1 = 80 high / 45 low; 0 = 40 high / 85 low), then low 5000 -> exactly one pixelValid, pixel = 0xFF0000, frameDone once, frameLen = 1, no bitErr.
- Four-pixel frame: 0x00FF00, 0x0000FF, 0xAAAAAA, 0x123456 back to back, then latch -> four pixelValid pulses with those values in order, pixelCount stepping 1..4, frameLen = 4.
- Glitch and boundaries:
  - a 10-cycle high spike inside a pixel is ignored and the pixel still decodes correctly;
  - highs of 59 and 60 cycles decode to 0 and 1 respectively.
- Over-long high: a 200-cycle high mid-pixel -> bitErr one cycle after the fall, no pixelValid. The next frame is ignored until 5000 low cycles, then decodes correctly.
- Partial pixel: 12 bits then latch -> frameDone with bitErr in the same cycle, frameLen = 0, pixel unchanged.
- Async reset asserted mid-pixel (bit 7) -> all outputs 0 immediately. A fresh frame sent without a preceding 5000-cycle low produces no pixelValid.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812B definitions: line timing at 100 MHz (used by both the transmitter
// and this receiver), decoder widths and the receiver state encoding.
package ws2812_pkg;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned T0H_CYC     = 40;
    localparam int unsigned T1H_CYC     = 80;
    localparam int unsigned PERIOD_CYC  = 125;
    localparam int unsigned LATCH_CYC   = 5000;

    localparam int unsigned T_MIN_HIGH_DEF = 15;
    localparam int unsigned T_THRESH_DEF   = 60;
    localparam int unsigned T_MAX_HIGH_DEF = 110;

    localparam int unsigned HIGH_CNT_W = 8;
    localparam int unsigned LOW_CNT_W  = 13;
    localparam int unsigned PIXEL_W    = 24;
    localparam int unsigned BIT_CNT_W  = 5;
    localparam int unsigned PIX_CNT_W  = 8;

    localparam logic [1:0] ST_WAIT_LATCH = 2'd0;
    localparam logic [1:0] ST_IDLE       = 2'd1;
    localparam logic [1:0] ST_HIGH       = 2'd2;
    localparam logic [1:0] ST_LOW        = 2'd3;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    // MSB-first shift: the first received bit ends up in the top position.
    function automatic logic [PIXEL_W-1:0] shift_in(input logic [PIXEL_W-1:0] sh,
                                                    input logic              b);
        return {sh[PIXEL_W-2:0], b};
    endfunction

endpackage

// File: rtl/ws2812_pulse_meas.sv
// Line front end: synchronizer, edge detect, high/low pulse timers and
// classification of each completed high pulse.
module ws2812_pulse_meas
    import ws2812_pkg::*;
#(
    parameter int unsigned T_MIN_HIGH = T_MIN_HIGH_DEF,
    parameter int unsigned T_THRESH   = T_THRESH_DEF,
    parameter int unsigned T_MAX_HIGH = T_MAX_HIGH_DEF,
    parameter int unsigned T_LATCH    = LATCH_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_rise_c,
    output logic o_bit_strobe_c,
    output logic o_bit_val_c,
    output logic o_glitch_c,
    output logic o_too_long_c,
    output logic o_latch_seen_c
);

    logic                  r_sync1;
    logic                  r_s;
    logic                  r_s_prev;
    logic [HIGH_CNT_W-1:0] r_high_cnt;
    logic [LOW_CNT_W-1:0]  r_low_cnt;

    logic w_rise;
    logic w_fall;

    assign w_rise = r_s & ~r_s_prev;
    assign w_fall = ~r_s & r_s_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_s        <= 1'b0;
            r_s_prev   <= 1'b0;
            r_high_cnt <= '0;
            r_low_cnt  <= '0;
        end else begin
            r_sync1  <= i_line;
            r_s      <= r_sync1;
            r_s_prev <= r_s;

            // High time includes the rise cycle; holds its value through the fall cycle.
            if (w_rise) begin
                r_high_cnt <= HIGH_CNT_W'(1);
            end else if (r_s && (r_high_cnt != HIGH_CNT_W'(T_MAX_HIGH))) begin
                r_high_cnt <= r_high_cnt + HIGH_CNT_W'(1);
            end

            if (r_s) begin
                r_low_cnt <= '0;
            end else if (r_low_cnt != LOW_CNT_W'(T_LATCH)) begin
                r_low_cnt <= r_low_cnt + LOW_CNT_W'(1);
            end
        end
    end

    always_comb begin
        o_rise_c       = w_rise;
        o_glitch_c     = w_fall && (r_high_cnt <  HIGH_CNT_W'(T_MIN_HIGH));
        o_too_long_c   = w_fall && (r_high_cnt >= HIGH_CNT_W'(T_MAX_HIGH));
        o_bit_strobe_c = w_fall && !o_glitch_c && !o_too_long_c;
        o_bit_val_c    = (r_high_cnt >= HIGH_CNT_W'(T_THRESH));
        // Fires only on the cycle the low counter steps onto the latch count.
        o_latch_seen_c = !r_s && (r_low_cnt == LOW_CNT_W'(T_LATCH - 1));
    end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812B receiver: turns classified line pulses into 24-bit GRB pixels and
// frame-end events, with frame resync after reset or protocol errors.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned T_MIN_HIGH = T_MIN_HIGH_DEF,
    parameter int unsigned T_THRESH   = T_THRESH_DEF,
    parameter int unsigned T_MAX_HIGH = T_MAX_HIGH_DEF,
    parameter int unsigned T_LATCH    = LATCH_CYC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lineIn,
    output logic [PIXEL_W-1:0]   pixel,
    output logic                 pixelValid,
    output logic [PIX_CNT_W-1:0] pixelCount,
    output logic                 frameDone,
    output logic [PIX_CNT_W-1:0] frameLen,
    output logic                 bitErr
);

    logic w_rise;
    logic w_bit_strobe;
    logic w_bit_val;
    logic w_glitch;
    logic w_too_long;
    logic w_latch;

    ws2812_pulse_meas #(
        .T_MIN_HIGH (T_MIN_HIGH),
        .T_THRESH   (T_THRESH),
        .T_MAX_HIGH (T_MAX_HIGH),
        .T_LATCH    (T_LATCH)
    ) u_meas (
        .clk            (clk),
        .reset          (reset),
        .i_line         (lineIn),
        .o_rise_c       (w_rise),
        .o_bit_strobe_c (w_bit_strobe),
        .o_bit_val_c    (w_bit_val),
        .o_glitch_c     (w_glitch),
        .o_too_long_c   (w_too_long),
        .o_latch_seen_c (w_latch)
    );

    logic [1:0]           r_state;
    logic [PIXEL_W-1:0]   r_shift;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic                 r_any_bit;
    grb_t                 r_pixel;
    logic                 r_pixel_valid;
    logic [PIX_CNT_W-1:0] r_pixel_count;
    logic                 r_frame_done;
    logic [PIX_CNT_W-1:0] r_frame_len;
    logic                 r_bit_err;

    logic [1:0]           w_state_nxt;
    logic [PIXEL_W-1:0]   w_shift_nxt;
    logic [BIT_CNT_W-1:0] w_bit_cnt_nxt;
    logic                 w_any_bit_nxt;
    grb_t                 w_pixel_nxt;
    logic                 w_pixel_valid_nxt;
    logic [PIX_CNT_W-1:0] w_pixel_count_nxt;
    logic                 w_frame_done_nxt;
    logic [PIX_CNT_W-1:0] w_frame_len_nxt;
    logic                 w_bit_err_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_WAIT_LATCH;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_any_bit     <= 1'b0;
            r_pixel       <= '0;
            r_pixel_valid <= 1'b0;
            r_pixel_count <= '0;
            r_frame_done  <= 1'b0;
            r_frame_len   <= '0;
            r_bit_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift       <= w_shift_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_any_bit     <= w_any_bit_nxt;
            r_pixel       <= w_pixel_nxt;
            r_pixel_valid <= w_pixel_valid_nxt;
            r_pixel_count <= w_pixel_count_nxt;
            r_frame_done  <= w_frame_done_nxt;
            r_frame_len   <= w_frame_len_nxt;
            r_bit_err     <= w_bit_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_shift_nxt       = r_shift;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_any_bit_nxt     = r_any_bit;
        w_pixel_nxt       = r_pixel;
        w_pixel_valid_nxt = 1'b0;
        w_pixel_count_nxt = r_pixel_count;
        w_frame_done_nxt  = 1'b0;
        w_frame_len_nxt   = r_frame_len;
        w_bit_err_nxt     = 1'b0;

        case (r_state)
            ST_WAIT_LATCH: begin
                if (w_latch) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (w_too_long) begin
                    w_bit_err_nxt = 1'b1;
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = '0;
                    w_any_bit_nxt = 1'b0;
                    w_state_nxt   = ST_WAIT_LATCH;
                end else if (w_glitch) begin
                    w_state_nxt = ST_LOW;
                end else if (w_bit_strobe) begin
                    w_any_bit_nxt = 1'b1;
                    w_state_nxt   = ST_LOW;
                    w_shift_nxt   = shift_in(r_shift, w_bit_val);
                    if (r_bit_cnt == BIT_CNT_W'(PIXEL_W - 1)) begin
                        w_pixel_nxt       = grb_t'(shift_in(r_shift, w_bit_val));
                        w_pixel_valid_nxt = 1'b1;
                        w_bit_cnt_nxt     = '0;
                        if (r_pixel_count != {PIX_CNT_W{1'b1}}) begin
                            w_pixel_count_nxt = r_pixel_count + PIX_CNT_W'(1);
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end

            ST_LOW: begin
                if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                end else if (w_latch) begin
                    // A low phase reached only through glitches carries no frame.
                    if (r_any_bit) begin
                        w_frame_done_nxt = 1'b1;
                        w_frame_len_nxt  = r_pixel_count;
                        w_bit_err_nxt    = (r_bit_cnt != '0);
                    end
                    w_pixel_count_nxt = '0;
                    w_bit_cnt_nxt     = '0;
                    w_shift_nxt       = '0;
                    w_any_bit_nxt     = 1'b0;
                    w_state_nxt       = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_WAIT_LATCH;
            end
        endcase
    end

    assign pixel      = r_pixel;
    assign pixelValid = r_pixel_valid;
    assign pixelCount = r_pixel_count;
    assign frameDone  = r_frame_done;
    assign frameLen   = r_frame_len;
    assign bitErr     = r_bit_err;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: drives WS2812B waveforms and compares decoded
// pixels, frame events and errors against hand-computed values.
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        lineIn;
    logic [23:0] pixel;
    logic        pixelValid;
    logic [7:0]  pixelCount;
    logic        frameDone;
    logic [7:0]  frameLen;
    logic        bitErr;

    ws2812_rx dut (
        .clk        (clk),
        .reset      (reset),
        .lineIn     (lineIn),
        .pixel      (pixel),
        .pixelValid (pixelValid),
        .pixelCount (pixelCount),
        .frameDone  (frameDone),
        .frameLen   (frameLen),
        .bitErr     (bitErr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge.
    logic [23:0] pv_pix[$];
    logic [7:0]  pv_cnt[$];
    int          fd_n = 0;
    int          err_n = 0;
    int          fd_err_n = 0;
    int          pv_cyc = 0;
    int          err_cyc = 0;
    logic [7:0]  last_len = 8'd0;

    always @(negedge clk) begin
        if (!reset) begin
            if (pixelValid) begin
                pv_pix.push_back(pixel);
                pv_cnt.push_back(pixelCount);
                pv_cyc = cyc;
            end
            if (frameDone) begin
                fd_n     = fd_n + 1;
                last_len = frameLen;
                if (bitErr) fd_err_n = fd_err_n + 1;
            end
            if (bitErr) begin
                err_n   = err_n + 1;
                err_cyc = cyc;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int fall_cyc = 0;
    int b_pv, b_fd, b_err, b_fde;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_pv  = pv_pix.size();
        b_fd  = fd_n;
        b_err = err_n;
        b_fde = fd_err_n;
    endtask

    task automatic idle_low(input int n);
        lineIn = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        lineIn = 1'b1;
        repeat (hi) @(negedge clk);
        lineIn   = 1'b0;
        fall_cyc = cyc;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) pulse(80, 45);
        else   pulse(40, 85);
    endtask

    task automatic send_pixel(input logic [23:0] v);
        for (int i = 23; i >= 0; i--) send_bit(v[i]);
    endtask

    logic [23:0] quad[4];
    logic [21:0] tail;
    logic [23:0] gpix;

    initial begin
        quad[0] = 24'h00FF00;
        quad[1] = 24'h0000FF;
        quad[2] = 24'hAAAAAA;
        quad[3] = 24'h123456;
        tail    = 22'h0F0F0F;
        gpix    = 24'hA5C30F;

        reset  = 1'b1;
        lineIn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pixel", 32'(pixel), 32'h0);
        check("rst_count", 32'(pixelCount), 32'h0);
        check("rst_flen", 32'(frameLen), 32'h0);
        check("rst_pulses", 32'({pixelValid, frameDone, bitErr}), 32'h0);
        reset = 1'b0;

        // Startup sync then a single pixel frame.
        snap();
        idle_low(5010);
        send_pixel(24'hFF0000);
        check("start_latency", 32'(pv_cyc - fall_cyc), 32'd3);
        idle_low(5050);
        check("start_npix", 32'(pv_pix.size() - b_pv), 32'd1);
        check("start_pix", 32'(pv_pix[b_pv]), 32'hFF0000);
        check("start_fd", 32'(fd_n - b_fd), 32'd1);
        check("start_flen", 32'(last_len), 32'd1);
        check("start_err", 32'(err_n - b_err), 32'd0);

        // Four back-to-back pixels.
        snap();
        for (int p = 0; p < 4; p++) send_pixel(quad[p]);
        idle_low(5050);
        check("quad_npix", 32'(pv_pix.size() - b_pv), 32'd4);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("quad_pix%0d", p), 32'(pv_pix[b_pv + p]), 32'(quad[p]));
            check($sformatf("quad_cnt%0d", p), 32'(pv_cnt[b_pv + p]), 32'(p + 1));
        end
        check("quad_fd", 32'(fd_n - b_fd), 32'd1);
        check("quad_flen", 32'(last_len), 32'd4);
        check("quad_err", 32'(err_n - b_err), 32'd0);
        check("quad_cnt_clr", 32'(pixelCount), 32'd0);
        check("quad_pix_hold", 32'(pixel), 32'h123456);

        // Glitch inside a pixel, then 59/60-cycle boundary highs.
        snap();
        for (int i = 23; i >= 0; i--) begin
            send_bit(gpix[i]);
            if (i == 18) pulse(10, 30);
        end
        pulse(59, 66);
        pulse(60, 65);
        for (int i = 21; i >= 0; i--) send_bit(tail[i]);
        idle_low(5050);
        check("glitch_npix", 32'(pv_pix.size() - b_pv), 32'd2);
        check("glitch_pix", 32'(pv_pix[b_pv]), 32'hA5C30F);
        check("bound_pix", 32'(pv_pix[b_pv + 1]), 32'h4F0F0F);
        check("glitch_flen", 32'(last_len), 32'd2);
        check("glitch_err", 32'(err_n - b_err), 32'd0);

        // Over-long high mid-pixel, then resync.
        snap();
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        pulse(200, 40);
        check("long_err", 32'(err_n - b_err), 32'd1);
        check("long_err_lat", 32'(err_cyc - fall_cyc), 32'd3);
        send_pixel(24'hC3C3C3);
        idle_low(5050);
        check("long_ign_npix", 32'(pv_pix.size() - b_pv), 32'd0);
        check("long_ign_fd", 32'(fd_n - b_fd), 32'd0);
        send_pixel(24'h5A5A5A);
        idle_low(5050);
        check("long_rec_npix", 32'(pv_pix.size() - b_pv), 32'd1);
        check("long_rec_pix", 32'(pv_pix[b_pv]), 32'h5A5A5A);
        check("long_rec_fd", 32'(fd_n - b_fd), 32'd1);
        check("long_rec_flen", 32'(last_len), 32'd1);
        check("long_err_total", 32'(err_n - b_err), 32'd1);

        // Partial pixel at latch.
        snap();
        for (int i = 0; i < 12; i++) send_bit(i[1]);
        idle_low(5050);
        check("part_fd", 32'(fd_n - b_fd), 32'd1);
        check("part_fd_err", 32'(fd_err_n - b_fde), 32'd1);
        check("part_err", 32'(err_n - b_err), 32'd1);
        check("part_flen", 32'(last_len), 32'd0);
        check("part_npix", 32'(pv_pix.size() - b_pv), 32'd0);
        check("part_pix_hold", 32'(pixel), 32'h5A5A5A);

        // Async reset during bit 7, then a frame with no leading latch gap.
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        lineIn = 1'b1;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_pixel", 32'(pixel), 32'h0);
        check("arst_count", 32'(pixelCount), 32'h0);
        check("arst_pulses", 32'({pixelValid, frameDone, bitErr}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        lineIn = 1'b0;
        repeat (2) @(negedge clk);
        snap();
        send_pixel(24'h00FF00);
        idle_low(5050);
        check("arst_npix", 32'(pv_pix.size() - b_pv), 32'd0);
        check("arst_fd", 32'(fd_n - b_fd), 32'd0);
        check("arst_err", 32'(err_n - b_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
